// File: rtl/seq110_defs.sv
// State encodings for the "110" pattern generator and its detector-side peers.
package seq110_defs;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B1   = 3'd1,
    B2   = 3'd2,
    B0   = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable unsigned down-counter that saturates at zero instead of wrapping.
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && !zero)
      cnt <= cnt - W'(1);
  end

  always_comb zero = (cnt == '0);

endmodule

// File: rtl/seq110_gen.sv
// Emits count back-to-back "110" patterns separated by gap idle zeros, then a done pulse.
module seq110_gen
  import seq110_defs::*;
#(
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  state_t             state, state_nx;
  logic [GAP_W-1:0]   gap_len;
  logic               rem_load, rem_dec, gap_load, gap_dec;
  logic [CNT_W-1:0]   rem_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               rem_zero, gap_zero;

  seq_down_cnt #(.W(CNT_W)) u_rem_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rem_load),
    .load_val (count),
    .dec      (rem_dec),
    .cnt      (rem_cnt),
    .zero     (rem_zero)
  );

  seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_len),
    .dec      (gap_dec),
    .cnt      (gap_cnt),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gap_len <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start)
        gap_len <= gap;
    end
  end

  // The zero terms only guard against a counter that was never loaded.
  always_comb begin
    state_nx = state;
    rem_load = 1'b0;
    rem_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            rem_load = 1'b1;
            state_nx = B1;
          end else begin
            state_nx = DONE;
          end
        end
      end
      B1: state_nx = B2;
      B2: state_nx = B0;
      B0: begin
        rem_dec = 1'b1;
        if (rem_zero || rem_cnt == CNT_W'(1)) begin
          state_nx = DONE;
        end else if (gap_len == '0) begin
          state_nx = B1;
        end else begin
          gap_load = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_zero || gap_cnt == GAP_W'(1))
          state_nx = B1;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dout = (state == B1) || (state == B2);
    busy = (state == B1) || (state == B2) || (state == B0) || (state == GAP);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_seq110_gen.sv
// Randomised and directed bursts checked against a pattern-list model of the generator.
module tb_seq110_gen;

  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap;
  logic             dout, busy, done;

  int checks = 0;
  int errors = 0;

  seq110_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .count (count),
    .gap   (gap),
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; abort_at >= 0 pulls reset low during that burst bit.
  task automatic run_burst(input int n, input int g, input int abort_at);
    bit         q[$];
    int         dets;
    logic [2:0] sh;
    for (int i = 0; i < n; i++) begin
      q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b0);
      if (i < n - 1)
        for (int j = 0; j < g; j++) q.push_back(1'b0);
    end
    start = 1'b1;
    count = CNT_W'(n);
    gap   = GAP_W'(g);
    @(negedge clk);
    start = 1'b0;
    sh    = '0;
    dets  = 0;
    for (int k = 0; k < q.size(); k++) begin
      if (k == abort_at) begin
        #1 rst = 1'b0;
        #1;
        chk("abort_dout", 32'(dout), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        repeat (2) begin
          @(negedge clk);
          chk("abort_hold_done", 32'(done), 0);
          chk("abort_hold_busy", 32'(busy), 0);
        end
        rst = 1'b1;
        return;
      end
      chk($sformatf("dout n=%0d g=%0d bit%0d", n, g, k), 32'(dout), 32'(q[k]));
      chk("busy_in_burst", 32'(busy), 1);
      chk("done_in_burst", 32'(done), 0);
      sh = {sh[1:0], dout};
      if (sh == 3'b110) dets++;
      // Noise that must be ignored while busy.
      start = 1'($urandom_range(0, 1));
      count = CNT_W'($urandom);
      gap   = GAP_W'($urandom);
      @(negedge clk);
    end
    chk($sformatf("done n=%0d g=%0d", n, g), 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("dout_at_done", 32'(dout), 0);
    chk($sformatf("detections n=%0d", n), 32'(dets), 32'(n));
    start = 1'($urandom_range(0, 1));
    count = CNT_W'($urandom_range(1, 15));
    @(negedge clk);
    start = 1'b0;
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_dout", 32'(dout), 0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    count = '0;
    gap   = '0;
    repeat (2) @(negedge clk);
    chk("reset_dout", 32'(dout), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    rst = 1'b1;

    run_burst(1, 0, -1);
    run_burst(3, 2, -1);
    run_burst(0, 5, -1);
    run_burst(2, 1, -1);
    run_burst(4, 3, 10);
    run_burst(1, 0, -1);
    run_burst(15, 7, -1);
    for (int r = 0; r < 20; r++)
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
